// File: rtl/usb_turnaround_ctrl_if.sv
// Handshake bundle between the SIE/protocol FSM and the USB bus-turnaround sequencer.
// The master side drives the event inputs; the slave side is the sequencer itself.
interface usb_turnaround_ctrl_if;
    logic       rxEopDone_i;
    logic       txEopDone_i;
    logic       expectResponse_i;
    logic       rxGotSignal_i;
    logic       rxPacketDone_i;
    logic       txReq_i;
    logic       txGrant_o;
    logic       txLate_o;
    logic       respStarted_o;
    logic       respDone_o;
    logic       rxTimeout_o;
    logic       busy_o;
    logic [7:0] timeoutCnt_o;
    logic [7:0] lateCnt_o;

    modport master (
        output rxEopDone_i, txEopDone_i, expectResponse_i, rxGotSignal_i,
               rxPacketDone_i, txReq_i,
        input  txGrant_o, txLate_o, respStarted_o, respDone_o, rxTimeout_o,
               busy_o, timeoutCnt_o, lateCnt_o
    );

    modport slave (
        input  rxEopDone_i, txEopDone_i, expectResponse_i, rxGotSignal_i,
               rxPacketDone_i, txReq_i,
        output txGrant_o, txLate_o, respStarted_o, respDone_o, rxTimeout_o,
               busy_o, timeoutCnt_o, lateCnt_o
    );
endinterface

// File: rtl/usb_turnaround_ctrl.sv
// USB full-speed bus turnaround sequencer on clk48 with an internal bit-time prescaler.
// Define USB_TURNAROUND_STATS_EN to build the saturating timeout/late statistics counters.
module usb_turnaround_ctrl #(
    parameter int CLK_PER_BIT         = 4,
    parameter int TIMEOUT_BITS        = 17,
    parameter int MIN_TURNAROUND_BITS = 2,
    parameter int MAX_TURNAROUND_BITS = 7
) (
    input  logic                   clk48_i,
    input  logic                   rst_i,
    usb_turnaround_ctrl_if.slave   bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HOLDOFF   = 3'd1;
    localparam logic [2:0] ST_WINDOW    = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_RESP_RX   = 3'd4;

    localparam int         PW         = $clog2(CLK_PER_BIT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_BIT - 1);
    localparam logic [7:0] BIT_SAT    = 8'hFF;
    // Timer limits are compared one tick early so a pulse lands exactly N bit times after entry.
    localparam logic [7:0] HOLD_LAST  = 8'(MIN_TURNAROUND_BITS - 1);
    localparam logic [7:0] WIN_LAST   = 8'(MAX_TURNAROUND_BITS - MIN_TURNAROUND_BITS - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_BITS - 1);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    bit_q, bit_d;
    logic          grant_q, grant_d;
    logic          late_q, late_d;
    logic          started_q, started_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          tick_s;
    logic          end_s;

    function automatic logic reached(input logic tick, input logic [7:0] cnt,
                                     input logic [7:0] last);
        return tick && (cnt == last);
    endfunction

    assign tick_s = (presc_q == PRESC_LAST);
    // A terminating pulse was issued last cycle: the state lingers for it, then returns to IDLE.
    assign end_s  = grant_q | late_q | timeout_q | done_q;

    // Next-state and pulse decode
    always_comb begin
        state_d   = state_q;
        grant_d   = 1'b0;
        late_d    = 1'b0;
        started_d = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rxEopDone_i) begin
                    state_d = ST_HOLDOFF;
                end else if (bus.txEopDone_i && bus.expectResponse_i) begin
                    state_d = ST_WAIT_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                // The grant decided here appears on the first TX_WINDOW cycle.
                if (reached(tick_s, bit_q, HOLD_LAST)) begin
                    state_d = ST_WINDOW;
                    grant_d = bus.txReq_i;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_WINDOW: begin
                if (end_s) begin
                    state_d = ST_IDLE;
                end else if (bus.txReq_i) begin
                    grant_d = 1'b1;
                end else if (reached(tick_s, bit_q, WIN_LAST)) begin
                    late_d = 1'b1;
                end else begin
                    state_d = ST_WINDOW;
                end
            end
            ST_WAIT_RESP: begin
                if (end_s) begin
                    state_d = ST_IDLE;
                end else if (bus.rxGotSignal_i) begin
                    started_d = 1'b1;
                    state_d   = ST_RESP_RX;
                end else if (reached(tick_s, bit_q, TO_LAST)) begin
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_RESP_RX: begin
                if (end_s) begin
                    state_d = ST_IDLE;
                end else if (bus.rxPacketDone_i) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RESP_RX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler and saturating bit counter, cleared on every state entry
    always_comb begin
        presc_d = presc_q;
        bit_d   = bit_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            presc_d = '0;
            bit_d   = 8'd0;
        end else if (tick_s) begin
            presc_d = '0;
            bit_d   = (bit_q == BIT_SAT) ? bit_q : (bit_q + 8'd1);
        end else begin
            presc_d = presc_q + PW'(1);
            bit_d   = bit_q;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // State, timebase and registered outputs
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            bit_q     <= 8'd0;
            grant_q   <= 1'b0;
            late_q    <= 1'b0;
            started_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bit_q     <= bit_d;
            grant_q   <= grant_d;
            late_q    <= late_d;
            started_q <= started_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.txGrant_o     = grant_q;
    assign bus.txLate_o      = late_q;
    assign bus.respStarted_o = started_q;
    assign bus.respDone_o    = done_q;
    assign bus.rxTimeout_o   = timeout_q;
    assign bus.busy_o        = busy_q;

`ifdef USB_TURNAROUND_STATS_EN
    logic [7:0] timeout_cnt_q;
    logic [7:0] late_cnt_q;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            timeout_cnt_q <= 8'd0;
            late_cnt_q    <= 8'd0;
        end else begin
            if (timeout_d && (timeout_cnt_q != 8'hFF)) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
            if (late_d && (late_cnt_q != 8'hFF)) begin
                late_cnt_q <= late_cnt_q + 8'd1;
            end
        end
    end

    assign bus.timeoutCnt_o = timeout_cnt_q;
    assign bus.lateCnt_o    = late_cnt_q;
`else
    assign bus.timeoutCnt_o = 8'd0;
    assign bus.lateCnt_o    = 8'd0;
`endif

endmodule

// File: tb/tb_usb_turnaround_ctrl.sv
// Scoreboard bench for usb_turnaround_ctrl: expected pulses (kind, cycle) are queued when
// stimulus is applied and popped when the DUT pulses; busy/stat outputs are spot-checked.
module tb_usb_turnaround_ctrl;

    localparam int CPB   = 4;
    localparam int TOB   = 17;
    localparam int MINB  = 2;
    localparam int MAXB  = 7;
    localparam int STATS =
`ifdef USB_TURNAROUND_STATS_EN
        1;
`else
        0;
`endif

    localparam logic [4:0] K_GRANT = 5'b00001;
    localparam logic [4:0] K_LATE  = 5'b00010;
    localparam logic [4:0] K_START = 5'b00100;
    localparam logic [4:0] K_DONE  = 5'b01000;
    localparam logic [4:0] K_TO    = 5'b10000;

    typedef struct {
        int         at;
        logic [4:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [4:0] mon_p;
    int   e;

    usb_turnaround_ctrl_if bus();

    usb_turnaround_ctrl #(
        .CLK_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB),
        .MIN_TURNAROUND_BITS(MINB),
        .MAX_TURNAROUND_BITS(MAXB)
    ) dut (
        .clk48_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push(input int at, input logic [4:0] kind);
        exp_t x;
        x.at   = at;
        x.kind = kind;
        sb.push_back(x);
    endtask

    // Compare every pulse against the scoreboard head.
    always @(negedge clk) begin
        mon_p = {bus.rxTimeout_o, bus.respDone_o, bus.respStarted_o, bus.txLate_o, bus.txGrant_o};
        if (mon_p != 5'd0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'(mon_p), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", int'(mon_p), int'(mon_e.kind));
                chk("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // One-cycle event pulse; entry returns the cycle the DUT reacts (state entered).
    task automatic pulse_in(input logic rx, input logic tx, input logic expr, output int entry);
        @(negedge clk);
        bus.rxEopDone_i      = rx;
        bus.txEopDone_i      = tx;
        bus.expectResponse_i = expr;
        entry = cyc + 1;
        @(negedge clk);
        bus.rxEopDone_i      = 1'b0;
        bus.txEopDone_i      = 1'b0;
        bus.expectResponse_i = 1'b0;
    endtask

    task automatic pulse_got();
        bus.rxGotSignal_i = 1'b1;
        @(negedge clk);
        bus.rxGotSignal_i = 1'b0;
    endtask

    task automatic pulse_pkt();
        bus.rxPacketDone_i = 1'b1;
        @(negedge clk);
        bus.rxPacketDone_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy_o), 0);
        chk({tag, "_pulses"}, int'({bus.txGrant_o, bus.txLate_o, bus.respStarted_o,
                                   bus.respDone_o, bus.rxTimeout_o}), 0);
        chk({tag, "_tocnt"}, int'(bus.timeoutCnt_o), 0);
        chk({tag, "_latecnt"}, int'(bus.lateCnt_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxEopDone_i      = 1'b0;
        bus.txEopDone_i      = 1'b0;
        bus.expectResponse_i = 1'b0;
        bus.rxGotSignal_i    = 1'b0;
        bus.rxPacketDone_i   = 1'b0;
        bus.txReq_i          = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // IDLE ignores response-side events
        pulse_got();
        pulse_pkt();
        repeat (3) @(negedge clk);
        chk("idle_ignore_busy", int'(bus.busy_o), 0);

        // Grant with txReq held: exactly MIN bits after holdoff entry, once only
        bus.txReq_i = 1'b1;
        pulse_in(1'b1, 1'b0, 1'b0, e);
        push(e + MINB * CPB, K_GRANT);
        wait_until(e);
        chk("grant_busy_entry", int'(bus.busy_o), 1);
        wait_until(e + MINB * CPB);
        chk("grant_busy_pulse", int'(bus.busy_o), 1);
        wait_until(e + MINB * CPB + 1);
        chk("grant_busy_after", int'(bus.busy_o), 0);
        wait_until(e + 40);
        bus.txReq_i = 1'b0;

        // No request: late at MAX bits after holdoff entry
        pulse_in(1'b1, 1'b0, 1'b0, e);
        push(e + MAXB * CPB, K_LATE);
        wait_until(e + MAXB * CPB + 1);
        chk("late_busy_after", int'(bus.busy_o), 0);
        chk("late_cnt_1", int'(bus.lateCnt_o), STATS);

        // Handshake expected, silence: timeout at TIMEOUT bits
        pulse_in(1'b0, 1'b1, 1'b1, e);
        push(e + TOB * CPB, K_TO);
        wait_until(e + TOB * CPB - 1);
        chk("to_busy_before", int'(bus.busy_o), 1);
        wait_until(e + TOB * CPB + 1);
        chk("to_busy_after", int'(bus.busy_o), 0);
        chk("to_cnt_1", int'(bus.timeoutCnt_o), STATS);

        // Response starts at 40, finishes at 300
        pulse_in(1'b0, 1'b1, 1'b1, e);
        wait_until(e + 40);
        pulse_got();
        push(e + 41, K_START);
        wait_until(e + 300);
        pulse_pkt();
        push(e + 301, K_DONE);
        wait_until(e + 301);
        chk("resp_busy_pulse", int'(bus.busy_o), 1);
        wait_until(e + 302);
        chk("resp_busy_after", int'(bus.busy_o), 0);

        // Response start on the very cycle the timeout would fire: start wins
        pulse_in(1'b0, 1'b1, 1'b1, e);
        wait_until(e + TOB * CPB - 1);
        pulse_got();
        push(e + TOB * CPB, K_START);
        wait_until(e + TOB * CPB + 8);
        pulse_pkt();
        push(e + TOB * CPB + 9, K_DONE);
        wait_until(e + TOB * CPB + 12);
        chk("coinc_to_cnt", int'(bus.timeoutCnt_o), STATS);

        // rxEopDone and txEopDone together: holdoff path (late at 28, not timeout at 68)
        pulse_in(1'b1, 1'b1, 1'b1, e);
        push(e + MAXB * CPB, K_LATE);
        wait_until(e + TOB * CPB + 4);
        chk("both_busy_after", int'(bus.busy_o), 0);
        chk("late_cnt_2", int'(bus.lateCnt_o), 2 * STATS);

        // Reset mid WAIT_RESP
        pulse_in(1'b0, 1'b1, 1'b1, e);
        wait_until(e + 20);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_wait");
        rst = 1'b0;
        wait_until(e + TOB * CPB + 20);
        chk("rst_wait_idle", int'(bus.busy_o), 0);

        // Reset mid TX_HOLDOFF with a pending request
        bus.txReq_i = 1'b1;
        pulse_in(1'b1, 1'b0, 1'b0, e);
        wait_until(e + 4);
        rst = 1'b1;
        bus.txReq_i = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst = 1'b0;
        wait_until(e + MAXB * CPB + 10);
        chk("rst_hold_idle", int'(bus.busy_o), 0);

        // No handshake expected: stays idle
        pulse_in(1'b0, 1'b1, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            wait_until(e + i);
            chk("noexp_busy", int'(bus.busy_o), 0);
        end
        repeat (10) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_turnaround_ctrl.md
Name: usb_turnaround_ctrl

Overview:
Sequences bus turnaround around every packet the SIE sends or receives, on the 48 MHz clock only.
- After a received host packet ends, it holds off the device transmitter for the minimum inter-packet delay, then grants one transmission inside the allowed response window.
- After the device sends a packet that needs a handshake, it runs the response timeout and reports response-start, response-complete or timeout to the protocol FSM.
- Bit time is derived internally with a prescaler; no 12 MHz clock is used.

Parameters:
CLK_PER_BIT, 4, clk48 cycles per full-speed bit time (>=2)
TIMEOUT_BITS, 17, bit times in WAIT_RESP before timeout (legal range 16..17)
MIN_TURNAROUND_BITS, 2, bit times after host EOP before the transmitter may be granted
MAX_TURNAROUND_BITS, 7, bit times after host EOP after which a response is late

Ports:
clk48_i  in  1  single clock, 48 MHz
rst_i  in  1  synchronous reset, active-high
rxEopDone_i  in  1  pulse: received host packet ended (SE0-to-J)
txEopDone_i  in  1  pulse: own packet EOP finished on the bus
expectResponse_i  in  1  sampled with txEopDone_i: a handshake is expected
rxGotSignal_i  in  1  pulse: RX detected start of packet
rxPacketDone_i  in  1  pulse: RX finished the packet (any result)
txReq_i  in  1  level: protocol FSM wants to transmit
txGrant_o  out  1  pulse: transmitter may start now
txLate_o  out  1  pulse: response window expired without a grant
respStarted_o  out  1  pulse: response start seen in WAIT_RESP
respDone_o  out  1  pulse: response packet finished
rxTimeout_o  out  1  pulse: no response within TIMEOUT_BITS
busy_o  out  1  high in every state except IDLE
timeoutCnt_o  out  8  statistics, see Optional Feature
lateCnt_o  out  8  statistics, see Optional Feature

Behaviour:
Reset and outputs
- All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE.
- Reset in any state aborts the operation with no pulse emitted.

Timebase
- Prescaler counts 0..CLK_PER_BIT-1; bitCnt increments on prescaler wrap and saturates at its maximum.
- Both counters clear on every state entry.
- "N bits elapsed" means bitCnt==N, i.e. N*CLK_PER_BIT cycles after entry.

States
- IDLE:
  - rxEopDone_i -> TX_HOLDOFF.
  - txEopDone_i & expectResponse_i -> WAIT_RESP.
  - txEopDone_i & !expectResponse_i -> stay IDLE.
  - Other inputs are ignored.
  - If rxEopDone_i and txEopDone_i arrive in the same cycle, rxEopDone_i wins.
- TX_HOLDOFF:
  - txGrant_o is never asserted here; txReq_i is remembered implicitly as a level.
  - At MIN_TURNAROUND_BITS elapsed -> TX_WINDOW.
- TX_WINDOW:
  - If txReq_i=1: pulse txGrant_o for one cycle, then -> IDLE.
  - If MAX_TURNAROUND_BITS elapsed (counted from TX_HOLDOFF entry, i.e. the window is MAX-MIN bits) without a grant: pulse txLate_o, then -> IDLE.
  - If txReq_i and the window end coincide, the grant wins.
- WAIT_RESP:
  - rxGotSignal_i: pulse respStarted_o, then -> RESP_RX.
  - At TIMEOUT_BITS elapsed: pulse rxTimeout_o, then -> IDLE.
  - If rxGotSignal_i and the timeout coincide, the signal wins and no timeout is reported.
  - rxEopDone_i is ignored here.
- RESP_RX:
  - rxPacketDone_i: pulse respDone_o, then -> IDLE.
  - No timeout; the RX block guarantees packet termination.

Timing and pulses
- Pulse latency is one cycle after the triggering condition.
- Pulses are mutually exclusive per cycle.

Optional Feature:
Macro: USB_TURNAROUND_STATS_EN
- Defined:
  - timeoutCnt_o counts rxTimeout_o pulses; lateCnt_o counts txLate_o pulses.
  - Both are 8-bit, saturate at 255 and clear only on rst_i.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- Defaults, rxEopDone_i, txReq_i held high -> txGrant_o pulses exactly 8 cycles after TX_HOLDOFF entry (2 bits x 4), once only; busy_o drops the next cycle.
- rxEopDone_i, txReq_i never asserted -> txLate_o pulses at 28 cycles (7 bits x 4); no grant; lateCnt_o=1 with STATS_EN.
- txEopDone_i with expectResponse_i=1, no RX activity -> rxTimeout_o pulses at 68 cycles (17 x 4); busy_o low afterwards.
- txEopDone_i with expectResponse_i=1, rxGotSignal_i at cycle 40, rxPacketDone_i at cycle 300 -> respStarted_o at 40 and respDone_o at 300 (each one cycle later); no rxTimeout_o.
- rxGotSignal_i in the same cycle the timeout would fire -> respStarted_o only; also rxEopDone_i and txEopDone_i together from IDLE -> TX_HOLDOFF entered.
- rst_i asserted mid WAIT_RESP and mid TX_HOLDOFF -> all outputs 0, IDLE, no pulses; txEopDone_i with expectResponse_i=0 -> busy_o stays 0.
